// File: rtl/ace_snoop_responder_if.sv
// ace_snoop_responder_if: bundles the AC request, cache lookup, CR response and CD data channels of the snoop responder.
//   AC     : ac_valid_i/ac_ready_o handshake, ac_addr_i, ac_snoop_i, ac_prot_i
//   lookup : lookup_req_o/lookup_gnt_i handshake, lookup_addr_o/snoop_o/prot_o,
//            result strobe lookup_valid_i with hit/dirty/shared/data
//   CR     : cr_valid_o/cr_ready_i handshake, cr_resp_o = {WasUnique, IsShared, PassDirty, Error, DataTransfer}
//   CD     : cd_valid_o/cd_ready_i handshake, cd_data_o, cd_last_o
// The slave modport is the responder; the master modport is the surrounding interconnect and cache.
interface ace_snoop_responder_if #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned LineWidth = 128
);
    logic                 ac_valid_i;
    logic                 ac_ready_o;
    logic [AddrWidth-1:0] ac_addr_i;
    logic [3:0]           ac_snoop_i;
    logic [2:0]           ac_prot_i;
    logic                 lookup_req_o;
    logic                 lookup_gnt_i;
    logic [AddrWidth-1:0] lookup_addr_o;
    logic [3:0]           lookup_snoop_o;
    logic [2:0]           lookup_prot_o;
    logic                 lookup_valid_i;
    logic                 lookup_hit_i;
    logic                 lookup_dirty_i;
    logic                 lookup_shared_i;
    logic [LineWidth-1:0] lookup_data_i;
    logic                 cr_valid_o;
    logic                 cr_ready_i;
    logic [4:0]           cr_resp_o;
    logic                 cd_valid_o;
    logic                 cd_ready_i;
    logic [DataWidth-1:0] cd_data_o;
    logic                 cd_last_o;

    modport slave (
        input  ac_valid_i, ac_addr_i, ac_snoop_i, ac_prot_i,
        output ac_ready_o,
        output lookup_req_o, lookup_addr_o, lookup_snoop_o, lookup_prot_o,
        input  lookup_gnt_i, lookup_valid_i, lookup_hit_i, lookup_dirty_i, lookup_shared_i, lookup_data_i,
        output cr_valid_o, cr_resp_o,
        input  cr_ready_i,
        output cd_valid_o, cd_data_o, cd_last_o,
        input  cd_ready_i
    );

    modport master (
        output ac_valid_i, ac_addr_i, ac_snoop_i, ac_prot_i,
        input  ac_ready_o,
        input  lookup_req_o, lookup_addr_o, lookup_snoop_o, lookup_prot_o,
        output lookup_gnt_i, lookup_valid_i, lookup_hit_i, lookup_dirty_i, lookup_shared_i, lookup_data_i,
        input  cr_valid_o, cr_resp_o,
        output cr_ready_i,
        input  cd_valid_o, cd_data_o, cd_last_o,
        output cd_ready_i
    );
endinterface

// File: rtl/ace_snoop_responder.sv
// ace_snoop_responder: buffers ACE snoop requests, runs one cache lookup per snoop, returns CRRESP and streams the line on CD.
//   clk_i  : clock
//   rst_ni : synchronous active-low reset
//   bus    : slave side of ace_snoop_responder_if (AC in, lookup port, CR out, CD out)
module ace_snoop_responder #(
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned LineWidth   = 128,
    parameter int unsigned AcFifoDepth = 2
) (
    input logic clk_i,
    input logic rst_ni,
    ace_snoop_responder_if.slave bus
);
    localparam int unsigned Beats = LineWidth / DataWidth;
    localparam int unsigned BeatW = Beats > 1 ? $clog2(Beats) : 1;
    localparam int unsigned PtrW  = AcFifoDepth > 1 ? $clog2(AcFifoDepth) : 1;
    localparam int unsigned CntW  = $clog2(AcFifoDepth + 1);

    typedef enum logic [1:0] {IDLE, LOOKUP, WAIT, RESP} state_t;

    logic [AddrWidth-1:0] fifo_addr [AcFifoDepth];
    logic [3:0]           fifo_snoop [AcFifoDepth];
    logic [2:0]           fifo_prot [AcFifoDepth];
    logic [PtrW-1:0]      wr_ptr, rd_ptr;
    logic [CntW-1:0]      cnt;
    logic                 full, empty, push, pop;

    state_t               state_q, state_n;
    logic [AddrWidth-1:0] addr_q;
    logic [3:0]           snoop_q;
    logic [2:0]           prot_q;
    logic [4:0]           resp_q;
    logic [LineWidth-1:0] line_q;
    logic [BeatW-1:0]     beat_q;
    logic                 cr_done_q, cd_done_q;

    logic                 lookup_req, cr_valid, cd_valid, cr_fire, cd_fire, last_beat;
    logic [3:0]           head_snoop;
    logic                 head_dvm, head_err;
    logic                 lk_read, lk_clean, dt;
    logic [4:0]           resp_lk;

    assign full  = cnt == CntW'(AcFifoDepth);
    assign empty = cnt == '0;
    assign push  = bus.ac_valid_i && !full;

    // Snoop classification of the FIFO head decides whether a lookup is needed at all.
    assign head_snoop = fifo_snoop[rd_ptr];
    assign head_dvm   = head_snoop[3:1] == 3'b111;
    assign head_err   = !head_dvm && !(head_snoop inside {4'b0000, 4'b0001, 4'b0010, 4'b0011,
                                                          4'b0111, 4'b1000, 4'b1001, 4'b1101});

    // Response derived from the pre-snoop line state reported by the lookup.
    assign lk_read  = snoop_q inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111};
    assign lk_clean = snoop_q inside {4'b1000, 4'b1001};
    assign dt       = bus.lookup_hit_i && (lk_read || (lk_clean && bus.lookup_dirty_i));
    assign resp_lk  = {bus.lookup_hit_i && !bus.lookup_shared_i,
                       bus.lookup_hit_i && (snoop_q inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1000}),
                       dt && bus.lookup_dirty_i && (snoop_q inside {4'b0111, 4'b1000, 4'b1001}),
                       1'b0,
                       dt};

    assign last_beat = beat_q == BeatW'(Beats - 1);
    assign cr_fire   = cr_valid && bus.cr_ready_i;
    assign cd_fire   = cd_valid && bus.cd_ready_i;

    assign bus.ac_ready_o     = !full;
    assign bus.lookup_req_o   = lookup_req;
    assign bus.lookup_addr_o  = addr_q;
    assign bus.lookup_snoop_o = snoop_q;
    assign bus.lookup_prot_o  = prot_q;
    assign bus.cr_valid_o     = cr_valid;
    assign bus.cr_resp_o      = resp_q;
    assign bus.cd_valid_o     = cd_valid;
    assign bus.cd_data_o      = line_q[beat_q*DataWidth +: DataWidth];
    assign bus.cd_last_o      = cd_valid && last_beat;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                fifo_addr[wr_ptr]  <= bus.ac_addr_i;
                fifo_snoop[wr_ptr] <= bus.ac_snoop_i;
                fifo_prot[wr_ptr]  <= bus.ac_prot_i;
                wr_ptr <= wr_ptr == PtrW'(AcFifoDepth - 1) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr == PtrW'(AcFifoDepth - 1) ? '0 : rd_ptr + 1'b1;
            cnt <= cnt + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_n;
    end

    always_comb begin
        state_n    = state_q;
        pop        = 1'b0;
        lookup_req = 1'b0;
        cr_valid   = 1'b0;
        cd_valid   = 1'b0;
        case (state_q)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                state_n = (head_dvm || head_err) ? RESP : LOOKUP;
            end
            LOOKUP: begin
                lookup_req = 1'b1;
                if (bus.lookup_gnt_i) state_n = WAIT;
            end
            WAIT: if (bus.lookup_valid_i) state_n = RESP;
            RESP: begin
                cr_valid = !cr_done_q;
                cd_valid = resp_q[0] && !cd_done_q;
                // CR and CD finish independently; leave once both sides are done.
                if ((cr_done_q || bus.cr_ready_i) &&
                    (!resp_q[0] || cd_done_q || (bus.cd_ready_i && last_beat)))
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            addr_q    <= '0;
            snoop_q   <= '0;
            prot_q    <= '0;
            resp_q    <= '0;
            line_q    <= '0;
            beat_q    <= '0;
            cr_done_q <= 1'b0;
            cd_done_q <= 1'b0;
        end else begin
            if (pop) begin
                addr_q    <= fifo_addr[rd_ptr];
                snoop_q   <= head_snoop;
                prot_q    <= fifo_prot[rd_ptr];
                resp_q    <= head_err ? 5'b00010 : 5'b00000;
                beat_q    <= '0;
                cr_done_q <= 1'b0;
                cd_done_q <= 1'b0;
            end
            if (state_q == WAIT && bus.lookup_valid_i) begin
                resp_q <= resp_lk;
                line_q <= bus.lookup_data_i;
            end
            if (cr_fire) cr_done_q <= 1'b1;
            if (cd_fire) begin
                beat_q <= last_beat ? '0 : beat_q + 1'b1;
                if (last_beat) cd_done_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ace_snoop_responder.sv
// tb_ace_snoop_responder: directed and randomized snoops checked against a rule-level model of CRRESP and CD beats.
//   Drives AC, plays the cache lookup port and the CR/CD consumer through ace_snoop_responder_if.
module tb_ace_snoop_responder;
    logic clk_i = 1'b0;
    logic rst_ni;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk_i = ~clk_i;

    ace_snoop_responder_if #(.AddrWidth(64), .DataWidth(64), .LineWidth(128)) bus ();

    ace_snoop_responder #(
        .AddrWidth(64), .DataWidth(64), .LineWidth(128), .AcFifoDepth(2)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference rules for the snoop response, stated per ACSNOOP encoding.
    function automatic logic [4:0] exp_resp(input logic [3:0] sn, input logic h, input logic d, input logic s);
        bit rd, cl, dtx;
        if (sn inside {4'd14, 4'd15}) return 5'b00000;
        if (!(sn inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd13})) return 5'b00010;
        rd  = sn inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7};
        cl  = sn inside {4'd8, 4'd9};
        dtx = h && (rd || (cl && d));
        return {h && !s, h && (sn inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd8}),
                dtx && d && (sn inside {4'd7, 4'd8, 4'd9}), 1'b0, dtx};
    endfunction

    function automatic bit needs_lookup(input logic [3:0] sn);
        return sn inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd13};
    endfunction

    task automatic send_ac(input logic [63:0] addr, input logic [3:0] sn, input logic [2:0] pr);
        int w = 0;
        while (!bus.ac_ready_o && w < 50) begin @(negedge clk_i); w++; end
        check("ac_ready_wait", w < 50, 1);
        bus.ac_valid_i = 1'b1;
        bus.ac_addr_i  = addr;
        bus.ac_snoop_i = sn;
        bus.ac_prot_i  = pr;
        @(negedge clk_i);
        bus.ac_valid_i = 1'b0;
    endtask

    // Serves one snoop: plays the lookup port, then consumes CR and CD, checking everything against the model.
    task automatic serve(input logic [63:0] addr, input logic [3:0] sn, input logic [2:0] pr,
                         input logic h, input logic d, input logic s, input logic [127:0] data,
                         input int gd, input int vd, input int mode, input bit exact, input int rst_beat);
        logic [4:0]  er;
        logic [63:0] eb;
        int w = 0, k = 0, beats = 0, nb;
        bit cr_got = 0;
        logic v_cr, v_cd, r_cr, r_cd;
        er = exp_resp(sn, h, d, s);
        nb = er[0] ? 2 : 0;
        @(negedge clk_i);
        while (!(bus.lookup_req_o || bus.cr_valid_o) && w < 50) begin @(negedge clk_i); w++; end
        check("start_timeout", w < 50, 1);
        if (exact) check("start_latency", w, 0);
        if (needs_lookup(sn)) begin
            check("lookup_req", bus.lookup_req_o, 1);
            check("cr_early", bus.cr_valid_o, 0);
            check("lookup_fields", {bus.lookup_addr_o, bus.lookup_snoop_o, bus.lookup_prot_o}, {addr, sn, pr});
            repeat (gd) begin
                @(negedge clk_i);
                check("lookup_hold", {bus.lookup_req_o, bus.lookup_addr_o}, {1'b1, addr});
            end
            bus.lookup_gnt_i = 1'b1;
            @(negedge clk_i);
            bus.lookup_gnt_i = 1'b0;
            check("req_after_gnt", bus.lookup_req_o, 0);
            repeat (vd) begin
                @(negedge clk_i);
                check("cr_before_valid", bus.cr_valid_o, 0);
            end
            bus.lookup_valid_i  = 1'b1;
            bus.lookup_hit_i    = h;
            bus.lookup_dirty_i  = d;
            bus.lookup_shared_i = s;
            bus.lookup_data_i   = data;
            @(negedge clk_i);
            bus.lookup_valid_i = 1'b0;
            check("cr_after_valid", bus.cr_valid_o, 1);
        end else begin
            check("no_lookup", bus.lookup_req_o, 0);
            check("cr_direct", bus.cr_valid_o, 1);
        end
        while (!(cr_got && beats == nb) && k < 100) begin
            v_cr = bus.cr_valid_o;
            v_cd = bus.cd_valid_o;
            if (cr_got) check("cr_valid_after_ack", v_cr, 0);
            else if (v_cr) check("cr_resp", bus.cr_resp_o, er);
            if (nb == 0) check("cd_valid_nodata", v_cd, 0);
            else if (v_cd && beats < nb) begin
                if (beats == rst_beat) begin
                    rst_ni = 1'b0;
                    bus.cr_ready_i = 1'b0;
                    bus.cd_ready_i = 1'b0;
                    @(negedge clk_i);
                    check("rst_valids", {bus.cr_valid_o, bus.cd_valid_o, bus.lookup_req_o}, 3'b000);
                    check("rst_ac_ready", bus.ac_ready_o, 1);
                    rst_ni = 1'b1;
                    repeat (3) begin
                        @(negedge clk_i);
                        check("rst_dropped", {bus.cr_valid_o, bus.cd_valid_o, bus.lookup_req_o}, 3'b000);
                    end
                    return;
                end
                eb = data[beats*64 +: 64];
                check("cd_data", bus.cd_data_o, eb);
                check("cd_last", bus.cd_last_o, beats == nb - 1);
            end
            r_cr = mode == 1 ? (k >= 5) : mode == 2 ? 1'b1 : 1'($urandom_range(0, 1));
            r_cd = mode == 1 ? 1'b1 : mode == 2 ? (k >= 5) : 1'($urandom_range(0, 1));
            bus.cr_ready_i = r_cr;
            bus.cd_ready_i = r_cd;
            @(negedge clk_i);
            k++;
            if (v_cr && r_cr) cr_got = 1;
            if (v_cd && r_cd && nb != 0) beats++;
        end
        bus.cr_ready_i = 1'b0;
        bus.cd_ready_i = 1'b0;
        check("resp_timeout", k < 100, 1);
        check("idle_valids", {bus.cr_valid_o, bus.cd_valid_o}, 2'b00);
    endtask

    initial begin
        logic [127:0] line;
        logic [3:0]   sn;
        bus.ac_valid_i = 0; bus.ac_addr_i = 0; bus.ac_snoop_i = 0; bus.ac_prot_i = 0;
        bus.lookup_gnt_i = 0; bus.lookup_valid_i = 0; bus.lookup_hit_i = 0;
        bus.lookup_dirty_i = 0; bus.lookup_shared_i = 0; bus.lookup_data_i = 0;
        bus.cr_ready_i = 0; bus.cd_ready_i = 0;
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_ac_ready", bus.ac_ready_o, 1);
        check("rst_outputs", {bus.lookup_req_o, bus.cr_valid_o, bus.cd_valid_o, bus.cd_last_o,
                              bus.cr_resp_o, bus.cd_data_o}, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        line = {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        check("model_readshared", exp_resp(4'd1, 1, 0, 0), 5'b11001);
        send_ac(64'h1000, 4'd1, 3'd2);
        serve(64'h1000, 4'd1, 3'd2, 1, 0, 0, line, 0, 0, 2, 1, -1);
        send_ac(64'h2040, 4'd7, 3'd0);
        serve(64'h2040, 4'd7, 3'd0, 1, 1, 0, line, 1, 2, 2, 1, -1);
        send_ac(64'h3080, 4'd9, 3'd5);
        serve(64'h3080, 4'd9, 3'd5, 0, 1, 0, line, 0, 1, 2, 1, -1);
        send_ac(64'h40C0, 4'd14, 3'd0);
        serve(64'h40C0, 4'd14, 3'd0, 1, 1, 0, line, 0, 0, 2, 1, -1);
        send_ac(64'h5000, 4'd5, 3'd0);
        serve(64'h5000, 4'd5, 3'd0, 1, 1, 0, line, 0, 0, 2, 1, -1);

        send_ac(64'h6000, 4'd1, 3'd1);
        serve(64'h6000, 4'd1, 3'd1, 1, 0, 1, ~line, 0, 0, 1, 1, -1);
        send_ac(64'h7000, 4'd8, 3'd1);
        serve(64'h7000, 4'd8, 3'd1, 1, 1, 0, line ^ 128'h1234, 2, 0, 2, 1, -1);

        send_ac(64'hA000, 4'd0, 3'd1);
        send_ac(64'hB000, 4'd7, 3'd2);
        send_ac(64'hC000, 4'd8, 3'd3);
        check("ac_ready_full", bus.ac_ready_o, 0);
        serve(64'hA000, 4'd0, 3'd1, 1, 0, 1, line, 3, 1, 0, 0, -1);
        serve(64'hB000, 4'd7, 3'd2, 1, 1, 0, ~line, 0, 0, 0, 0, -1);
        serve(64'hC000, 4'd8, 3'd3, 1, 1, 1, line, 1, 0, 0, 0, -1);

        send_ac(64'hD000, 4'd1, 3'd0);
        send_ac(64'hE000, 4'd2, 3'd0);
        serve(64'hD000, 4'd1, 3'd0, 1, 0, 0, line, 0, 0, 1, 0, 1);

        repeat (40) begin
            logic [63:0] a;
            a    = {$urandom, $urandom};
            sn   = 4'($urandom_range(0, 15));
            line = {$urandom, $urandom, $urandom, $urandom};
            send_ac(a, sn, 3'($urandom_range(0, 7)));
            serve(a, sn, bus.ac_prot_i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), line, $urandom_range(0, 3), $urandom_range(0, 3), 0, 1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
